frame_extractor: RTL

- Stream stage directly downstream of the BoundaryDetector HLS core, inside the same RFNoC block.
- Consumes the detector's SC16 sample stream, where a 1-bit TUSER strobe marks each detected frame boundary.
- Cuts out one fixed-length frame per accepted boundary, starting a programmable offset after the boundary, and emits it as an AXI-Stream packet with TLAST on the final sample.
- Samples outside frames are discarded. Feeds the output pipeline FIFO and axi_wrapper, so every RFNoC packet equals one frame.

---
 rtl/frame_extractor_pkg.sv | 31 +++
 rtl/frame_extractor_if.sv | 37 +++
 rtl/frame_extractor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/frame_extractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_extractor_pkg
// Description : Shared types and constants for the frame extractor stage:
//               FSM state encoding, default widths, setting-register and
//               readback addresses used by the surrounding RFNoC block.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_extractor_pkg;

  localparam int DATA_W = 32;   // SC16 I/Q packed sample
  localparam int LEN_W  = 16;   // FRAME_LEN / OFFSET width
  localparam int CNT_W  = 32;   // status counter width

  // Setting-register addresses
  localparam logic [7:0] SR_FX_ENABLE = 8'd133;
  localparam logic [7:0] SR_FX_LEN    = 8'd134;
  localparam logic [7:0] SR_FX_OFFSET = 8'd135;

  // Readback addresses
  localparam logic [7:0] RB_FX_FRAME_CNT = 8'd2;
  localparam logic [7:0] RB_FX_DROP_CNT  = 8'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    FRAME = 2'd2
  } state_t;

endpackage : frame_extractor_pkg
`default_nettype wire

// File: rtl/frame_extractor_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_extractor_if
// Description : AXI-Stream bundle (TDATA/TUSER/TVALID/TREADY/TLAST) used for
//               both the sample input and the frame output of the extractor.
//   master : drives tdata, tuser, tvalid, tlast; receives tready
//   slave  : receives tdata, tuser, tvalid, tlast; drives tready
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_extractor_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] tdata;
  logic              tuser;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface : frame_extractor_if
`default_nettype wire

// File: rtl/frame_extractor.sv
`default_nettype none
// ============================================================================
// Module      : frame_extractor
// Description : Cuts one fixed-length frame out of the sample stream per
//               accepted boundary strobe (i_data.tuser), starting OFFSET
//               samples after the boundary, and emits it as one AXI-Stream
//               packet with TLAST on the final sample. Samples outside
//               frames are consumed and discarded.
//   ap_clk    : block clock
//   ap_rst_n  : synchronous active-low reset
//   i_data    : input sample stream (slave); tlast is ignored
//   o_data    : output frame stream (master); tuser driven 0
//   ENABLE    : 0 = accept no new boundaries
//   FRAME_LEN : samples per frame, 0 = extraction disabled
//   OFFSET    : samples between boundary and first output sample
//   FRAME_CNT : frames completed on the output
//   DROP_CNT  : boundaries ignored while in SKIP or FRAME
// Revision    : 1.0 - initial release
// ============================================================================
module frame_extractor #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  frame_extractor_if.slave  i_data,
  frame_extractor_if.master o_data,
  input  logic              ENABLE,
  input  logic [LEN_W-1:0]  FRAME_LEN,
  input  logic [LEN_W-1:0]  OFFSET,
  output logic [CNT_W-1:0]  FRAME_CNT,
  output logic [CNT_W-1:0]  DROP_CNT
);

  import frame_extractor_pkg::*;

  state_t              state_q,     state_d;
  logic [LEN_W-1:0]    len_q,       len_d;
  logic [LEN_W-1:0]    off_q,       off_d;
  logic [LEN_W-1:0]    skip_cnt_q,  skip_cnt_d;
  logic [LEN_W-1:0]    samp_cnt_q,  samp_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic                out_last_q,  out_last_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]    drop_cnt_q,  drop_cnt_d;

  logic                w_out_ready;
  logic                w_in_ready;
  logic                w_arm;
  logic                w_push;
  logic                w_push_last;
  logic                w_beat;
  logic                unused_tlast;

  // Upstream packet boundaries carry no meaning for framing.
  assign unused_tlast = i_data.tlast;

  // Single output register: it can take a new sample when empty or draining.
  assign w_out_ready = !out_valid_q || o_data.tready;

  // A boundary that would start a new frame if seen in IDLE.
  assign w_arm = i_data.tuser && ENABLE && (FRAME_LEN != '0);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    off_d       = off_q;
    skip_cnt_d  = skip_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    w_in_ready  = 1'b1;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_beat      = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero-offset boundary is forwarded immediately, so it must wait
        // for room in the output register; everything else is discarded.
        w_in_ready = (w_arm && (OFFSET == '0)) ? w_out_ready : 1'b1;
        w_beat     = i_data.tvalid && w_in_ready;
        if (w_beat && w_arm) begin
          len_d = FRAME_LEN;
          off_d = OFFSET;
          if (OFFSET == '0) begin
            w_push      = 1'b1;
            w_push_last = (FRAME_LEN == LEN_W'(1));
            samp_cnt_d  = LEN_W'(1);
            state_d     = w_push_last ? IDLE : FRAME;
          end else begin
            skip_cnt_d = LEN_W'(1);
            state_d    = SKIP;
          end
        end
      end

      SKIP: begin
        // The beat that becomes frame sample 0 is forwarded and needs room.
        w_in_ready = (skip_cnt_q == off_q) ? w_out_ready : 1'b1;
        w_beat     = i_data.tvalid && w_in_ready;
        if (w_beat) begin
          if (i_data.tuser) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end
          if (skip_cnt_q == off_q) begin
            w_push      = 1'b1;
            w_push_last = (len_q == LEN_W'(1));
            samp_cnt_d  = LEN_W'(1);
            state_d     = w_push_last ? IDLE : FRAME;
          end else begin
            skip_cnt_d = skip_cnt_q + LEN_W'(1);
          end
        end
      end

      FRAME: begin
        w_in_ready = w_out_ready;
        w_beat     = i_data.tvalid && w_in_ready;
        if (w_beat) begin
          if (i_data.tuser) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end
          w_push      = 1'b1;
          w_push_last = (samp_cnt_q == len_q - LEN_W'(1));
          samp_cnt_d  = samp_cnt_q + LEN_W'(1);
          if (w_push_last) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Output register load / drain. w_push only occurs with w_out_ready set.
    if (w_out_ready) begin
      out_valid_d = w_push;
      out_last_d  = w_push && w_push_last;
      if (w_push) begin
        out_data_d = i_data.tdata;
      end
    end

    if (out_valid_q && o_data.tready && out_last_q) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      off_q       <= '0;
      skip_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      off_q       <= off_d;
      skip_cnt_q  <= skip_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign i_data.tready = w_in_ready;
  assign o_data.tvalid = out_valid_q;
  assign o_data.tdata  = out_data_q;
  assign o_data.tlast  = out_last_q;
  assign o_data.tuser  = 1'b0;
  assign FRAME_CNT     = frame_cnt_q;
  assign DROP_CNT      = drop_cnt_q;

endmodule : frame_extractor
`default_nettype wire
